hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised load-use and multi-cycle interlock unit for the ID stage of the pipelined RISC-V core. It is the successor to the single-cycle load-use detector. It keeps a per-register countdown scoreboard of results that are not yet forwardable, so that loads, multiplies and other variable-latency producers share one stall mechanism. The block raises `stall` when the instruction in ID reads a register whose producer is still in flight. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register address width; the scoreboard tracks 2**REG_ADDR_WIDTH registers.
- `LAT_WIDTH`, 3, width of each countdown counter; the maximum tracked latency is 2**LAT_WIDTH-1 cycles.
- `STALL_CNT_WIDTH`, 16, width of the stall performance counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1 rising-edge clock.
- `reset` input 1 synchronous, active-high; clears all state.
- `id_valid` input 1 the ID stage holds a real instruction (not a bubble).
- `id_rs1` input REG_ADDR_WIDTH source register 1 of the ID instruction.
- `id_rs2` input REG_ADDR_WIDTH source register 2 of the ID instruction.
- `id_use_rs1` input 1 the ID instruction actually reads rs1.
- `id_use_rs2` input 1 the ID instruction actually reads rs2.
- `id_reg_write` input 1 the ID instruction writes rd.
- `id_rd` input REG_ADDR_WIDTH destination register of the ID instruction.
- `id_latency` input LAT_WIDTH number of cycles after issue during which the result is not forwardable (load = 1, ALU = 0, mul = 3).
- `flush` input 1 a taken branch or jump squashes the ID instruction this cycle.
- `stall` output 1 hold PC and IF/ID, and inject a bubble into ID/EX.
- `busy_mask` output 2**REG_ADDR_WIDTH bit r is 1 when cnt[r] != 0.
- `stall_count` output STALL_CNT_WIDTH saturating count of stalled cycles.

## Operation
- State: one counter cnt[r] of LAT_WIDTH bits per register. Register x0 is never tracked; cnt[0] stays 0.
- `stall` is combinational from registered state and ID inputs. It is 1 when `id_valid` is 1 and either source is busy:
  - `id_use_rs1` is 1, `id_rs1` != 0 and cnt[id_rs1] != 0, or
  - `id_use_rs2` is 1, `id_rs2` != 0 and cnt[id_rs2] != 0.
- Issue event: `id_valid` && !`stall` && !`flush`. This is the instruction moving into ID/EX this cycle.
- Next-state update, applied to every register r on each clock edge:
  - If an issue event occurs with `id_reg_write`=1, `id_rd`=r and r != 0, then cnt[r] <= `id_latency`. The load wins over decrement, and the new value replaces any older pending value.
  - Else if cnt[r] != 0, then cnt[r] <= cnt[r]-1.
  - Else cnt[r] stays 0.
- An issue with `id_latency`=0 leaves cnt[rd] at 0, so the normal forwarding path covers that producer.
- Self-dependency: if rs1 or rs2 equals rd and the older producer is busy, the instruction stalls on the old counter. It does not update the scoreboard until it issues.
- `flush` suppresses the issue event but does not clear existing counters, because older producers are already committed to EX/MEM. `flush` does not mask `stall`; the pipeline control gives flush priority.
- `stall_count` increments by 1 on each edge where `stall`=1 and holds at all-ones. It never wraps.
- `busy_mask` is the registered scoreboard state, with no combinational path from the inputs.

## Timing
- Reset: on the edge where `reset`=1, all cnt[r] <= 0 and `stall_count` <= 0. From that point `busy_mask`=0 and `stall`=0.
  - Reset has priority over an issue event in the same cycle.
  - Reset mid-stall releases the stall on the following cycle.
- Latency L issued at edge t:
  - cnt=L for cycles t+1 .. t+1, then counts down and reaches 0 after edge t+L.
  - A dependent instruction in ID is stalled for exactly L cycles; there are no extra bubbles.
- Load followed immediately by a use (L=1) gives one stall cycle, matching the classic load-use bubble.
- The stalled instruction is re-evaluated every cycle. `stall` falls in the same cycle the counter reaches 0.
- Throughput: one issue per cycle. The scoreboard update and `stall_count` update both complete in a single cycle.

## Test plan
- Reset check:
  - Drive arbitrary inputs with `reset`=1 for 2 cycles.
  - Required: `stall`=0, `busy_mask`=0 and `stall_count`=0 one cycle after reset.
- Load-use:
  - Issue a load with rd=5 and `id_latency`=1, then next cycle an instruction with rs1=5 and `id_use_rs1`=1.
  - Required: `stall`=1 for exactly 1 cycle, then 0, and `stall_count`=1.
- Multi-cycle mul:
  - Issue rd=7 with `id_latency`=3, followed by a reader of rs2=7.
  - Required: `stall` high for 3 consecutive cycles and `stall_count`=3.
  - Required: `busy_mask` bit 7 reads 1 for 3 cycles, then 0.
- x0 and unused operands:
  - Issue a load with rd=0. Separately, issue a load with rd=9 followed by an instruction with rs1=9 but `id_use_rs1`=0.
  - Required: no stall in either case, and `busy_mask` bit 0 stays 0.
- Overwrite and flush:
  - Issue rd=4 with L=3, then next cycle rd=4 with L=1, then a reader of 4. Required: the reader stalls 1 cycle.
  - Separately, issue rd=6 with L=2 while `flush`=1. Required: `busy_mask` bit 6 stays 0.
- Saturation:
  - Force continuous stalls for more than 2**STALL_CNT_WIDTH cycles, using a reduced `STALL_CNT_WIDTH`=4 instance.
  - Required: `stall_count` stops at 15 and never wraps.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage interlock: per-register countdown scoreboard of results that cannot be forwarded yet,
// producing a stall request for readers, a registered busy mask and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int LAT_WIDTH       = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rs2,
    input  logic                          id_use_rs1,
    input  logic                          id_use_rs2,
    input  logic                          id_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0]     id_rd,
    input  logic [LAT_WIDTH-1:0]          id_latency,
    input  logic                          flush,
    output logic                          stall,
    output logic [2**REG_ADDR_WIDTH-1:0]  busy_mask,
    output logic [STALL_CNT_WIDTH-1:0]    stall_count
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    logic [LAT_WIDTH-1:0]       cnt_q [NUM_REGS];
    logic [LAT_WIDTH-1:0]       cnt_d [NUM_REGS];
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_d;
    logic                       rs1_busy;
    logic                       rs2_busy;
    logic                       issue;

    // Handshake: id_valid offers the ID instruction; !stall accepts it. It moves into ID/EX
    // (an issue) only when offered, accepted and not squashed by flush in the same cycle.
    always_comb begin
        rs1_busy = id_use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
        rs2_busy = id_use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
        stall    = id_valid && (rs1_busy || rs2_busy);
        issue    = id_valid && !stall && !flush;
    end

    // A new producer replaces whatever was pending on its rd; x0 is never tracked.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (issue && id_reg_write && (id_rd == REG_ADDR_WIDTH'(r))) begin
                cnt_d[r] = id_latency;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance for interlock behaviour,
// narrow-counter instance for stall_count saturation.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_reg_write;
    logic [4:0]  id_rd;
    logic [2:0]  id_latency;
    logic        flush;
    logic        stall;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;

    logic        s_id_valid;
    logic [4:0]  s_id_rs1;
    logic        s_id_use_rs1;
    logic        s_id_reg_write;
    logic [4:0]  s_id_rd;
    logic [2:0]  s_id_latency;
    logic        s_stall;
    logic [31:0] s_busy_mask;
    logic [3:0]  s_stall_count;

    int n_assert;
    int n_fail;

    hazard_scoreboard u_dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_reg_write (id_reg_write),
        .id_rd        (id_rd),
        .id_latency   (id_latency),
        .flush        (flush),
        .stall        (stall),
        .busy_mask    (busy_mask),
        .stall_count  (stall_count)
    );

    hazard_scoreboard #(.STALL_CNT_WIDTH(4)) u_sat (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (s_id_valid),
        .id_rs1       (s_id_rs1),
        .id_rs2       (5'd0),
        .id_use_rs1   (s_id_use_rs1),
        .id_use_rs2   (1'b0),
        .id_reg_write (s_id_reg_write),
        .id_rd        (s_id_rd),
        .id_latency   (s_id_latency),
        .flush        (1'b0),
        .stall        (s_stall),
        .busy_mask    (s_busy_mask),
        .stall_count  (s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic wr,
                          input logic [4:0] rd, input logic [2:0] lat, input logic fl);
        id_valid     = v;
        id_rs1       = rs1;
        id_use_rs1   = u1;
        id_rs2       = rs2;
        id_use_rs2   = u2;
        id_reg_write = wr;
        id_rd        = rd;
        id_latency   = lat;
        flush        = fl;
    endtask

    // Inputs change at the falling edge; checks look #1 later, well before the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        s_id_valid = 0; s_id_rs1 = 0; s_id_use_rs1 = 0;
        s_id_reg_write = 0; s_id_rd = 0; s_id_latency = 0;

        // Reset with arbitrary activity on the ID inputs.
        reset = 1;
        set_id(1, 5'd3, 1, 5'd12, 1, 1, 5'd3, 3'd5, 0);
        next_cycle();
        set_id(1, 5'd17, 1, 5'd3, 1, 1, 5'd17, 3'd7, 1);
        next_cycle();
        reset = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_busy", busy_mask, 32'd0);
        check("reset_count", 32'(stall_count), 32'd0);
        next_cycle();

        // Load-use: one bubble.
        set_id(1, 0, 0, 0, 0, 1, 5'd5, 3'd1, 0);
        #1 check("lu_issue_stall", 32'(stall), 32'd0);
        next_cycle();
        set_id(1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
        #1 check("lu_stall", 32'(stall), 32'd1);
        check("lu_busy", busy_mask, 32'h0000_0020);
        next_cycle();
        #1 check("lu_release", 32'(stall), 32'd0);
        check("lu_busy_clear", busy_mask, 32'd0);
        check("lu_count", 32'(stall_count), 32'd1);
        next_cycle();

        // Multiply with latency 3 read via rs2.
        set_id(1, 0, 0, 0, 0, 1, 5'd7, 3'd3, 0);
        #1 check("mul_issue_stall", 32'(stall), 32'd0);
        next_cycle();
        set_id(1, 0, 0, 5'd7, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mul_stall_%0d", i), 32'(stall), 32'd1);
            check($sformatf("mul_busy7_%0d", i), 32'(busy_mask[7]), 32'd1);
            next_cycle();
        end
        #1 check("mul_release", 32'(stall), 32'd0);
        check("mul_busy7_clear", 32'(busy_mask[7]), 32'd0);
        check("mul_count", 32'(stall_count), 32'd4);
        next_cycle();

        // x0 destination and unused operand.
        set_id(1, 0, 0, 0, 0, 1, 5'd0, 3'd3, 0);
        next_cycle();
        set_id(1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0);
        #1 check("x0_stall", 32'(stall), 32'd0);
        check("x0_busy", busy_mask, 32'd0);
        next_cycle();
        set_id(1, 0, 0, 0, 0, 1, 5'd9, 3'd1, 0);
        next_cycle();
        set_id(1, 5'd9, 0, 5'd10, 1, 0, 0, 0, 0);
        #1 check("unused_rs1_stall", 32'(stall), 32'd0);
        check("unused_busy", busy_mask, 32'h0000_0200);
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("unused_count", 32'(stall_count), 32'd4);
        next_cycle();

        // Overwrite: newer shorter latency replaces the pending one.
        set_id(1, 0, 0, 0, 0, 1, 5'd4, 3'd3, 0);
        next_cycle();
        set_id(1, 0, 0, 0, 0, 1, 5'd4, 3'd1, 0);
        #1 check("ow_second_issue", 32'(stall), 32'd0);
        next_cycle();
        set_id(1, 5'd4, 1, 0, 0, 0, 0, 0, 0);
        #1 check("ow_stall", 32'(stall), 32'd1);
        check("ow_busy", busy_mask, 32'h0000_0010);
        next_cycle();
        #1 check("ow_release", 32'(stall), 32'd0);
        check("ow_busy_clear", busy_mask, 32'd0);
        next_cycle();

        // Flushed producer never enters the scoreboard.
        set_id(1, 0, 0, 0, 0, 1, 5'd6, 3'd2, 1);
        next_cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("flush_busy", busy_mask, 32'd0);
        next_cycle();

        // Flush neither masks stall nor clears older counters.
        set_id(1, 0, 0, 0, 0, 1, 5'd8, 3'd2, 0);
        next_cycle();
        set_id(1, 5'd8, 1, 0, 0, 0, 0, 0, 1);
        #1 check("flush_stall", 32'(stall), 32'd1);
        next_cycle();
        set_id(1, 5'd8, 1, 0, 0, 0, 0, 0, 0);
        #1 check("flush_keep_stall", 32'(stall), 32'd1);
        check("flush_keep_busy", busy_mask, 32'h0000_0100);
        next_cycle();
        #1 check("flush_release", 32'(stall), 32'd0);
        check("flush_count", 32'(stall_count), 32'd7);
        next_cycle();

        // Reset mid-stall, and reset beating a same-cycle issue.
        set_id(1, 0, 0, 0, 0, 1, 5'd3, 3'd5, 0);
        next_cycle();
        set_id(1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
        reset = 1;
        #1 check("rst_mid_stall", 32'(stall), 32'd1);
        next_cycle();
        reset = 0;
        #1 check("rst_mid_release", 32'(stall), 32'd0);
        check("rst_mid_count", 32'(stall_count), 32'd0);
        next_cycle();
        set_id(1, 0, 0, 0, 0, 1, 5'd2, 3'd3, 0);
        reset = 1;
        next_cycle();
        reset = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("rst_beats_issue", busy_mask, 32'd0);
        next_cycle();

        // Saturation on the 4-bit instance: three bursts of 7 stalls.
        for (int b = 1; b <= 3; b++) begin
            s_id_valid = 1; s_id_use_rs1 = 0; s_id_rs1 = 0;
            s_id_reg_write = 1; s_id_rd = 5'd1; s_id_latency = 3'd7;
            next_cycle();
            s_id_reg_write = 0; s_id_rd = 0; s_id_latency = 0;
            s_id_use_rs1 = 1; s_id_rs1 = 5'd1;
            for (int c = 0; c < 7; c++) begin
                next_cycle();
            end
            #1;
            check($sformatf("sat_release_%0d", b), 32'(s_stall), 32'd0);
            check($sformatf("sat_count_%0d", b), 32'(s_stall_count), (b * 7 > 15) ? 32'd15 : 32'(b * 7));
            next_cycle();
        end
        s_id_valid = 0; s_id_use_rs1 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
